// File: rtl/drac_pkg.sv
// Shared types for the DRAC data-cache interface: tracking-buffer entry,
// interface FSM states and the DMEM exception vector.
package drac_pkg;

  localparam int unsigned ENTRY_ADDR_W      = 64;
  localparam int unsigned ENTRY_DATA_W      = 64;
  localparam int unsigned RETRY_W           = 4;
  localparam int unsigned MAX_RETRY_DEFAULT = 7;

  typedef enum logic [1:0] {
    RUN,
    REWIND,
    FENCE
  } dcache_if_state_t;

  typedef struct packed {
    logic ma_ld;
    logic ma_st;
    logic pf_ld;
    logic pf_st;
  } dmem_xcpt_t;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
    logic                    we;
    logic [1:0]              size;
    logic                    fence;
    logic                    killed;
    logic [RETRY_W-1:0]      retry;
  } dcache_entry_t;

endpackage

// File: rtl/dmem_req_queue.sv
// In-order request tracking buffer: storage plus head/issue/tail pointers
// with push, pop, rewind (issue<-head) and truncate (tail<-issue).
module dmem_req_queue
  import drac_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  dcache_entry_t             push_entry,
  input  logic                      pop,
  input  logic                      issue_adv,
  input  logic                      rewind,
  input  logic                      truncate,
  input  logic                      retry_inc,
  output logic [$clog2(DEPTH):0]    head_ptr,
  output logic [$clog2(DEPTH):0]    issue_ptr,
  output logic [$clog2(DEPTH):0]    tail_ptr,
  output logic                      full,
  output logic                      head_killed,
  output logic [RETRY_W-1:0]        head_retry,
  output logic                      issue_fence,
  output logic                      nxt_pending,
  output logic [$clog2(DEPTH)-1:0]  nxt_tag,
  output logic [ENTRY_ADDR_W-1:0]   nxt_addr,
  output logic [ENTRY_DATA_W-1:0]   nxt_data,
  output logic                      nxt_we,
  output logic [1:0]                nxt_size,
  output logic                      nxt_fence
);

  localparam int unsigned TAG_W = $clog2(DEPTH);
  localparam int unsigned PW    = TAG_W + 1;

  dcache_entry_t mem [DEPTH];
  dcache_entry_t nxt_entry;
  logic [PW-1:0] head_n, issue_n, tail_n;

  // Kill is applied after the response update, so truncation uses the new issue pointer.
  always_comb begin
    head_n  = head_ptr + PW'(pop);
    issue_n = rewind ? head_n : issue_ptr + PW'(issue_adv);
    tail_n  = truncate ? issue_n : tail_ptr + PW'(push);
  end

  always_comb begin
    full        = (tail_ptr - head_ptr) == PW'(DEPTH);
    head_killed = mem[head_ptr[TAG_W-1:0]].killed;
    head_retry  = mem[head_ptr[TAG_W-1:0]].retry;
    issue_fence = mem[issue_ptr[TAG_W-1:0]].fence;
    nxt_pending = issue_n != tail_n;
    nxt_tag     = issue_n[TAG_W-1:0];
    // An entry pushed this cycle can already be the next one to issue.
    nxt_entry   = (push && issue_n == tail_ptr) ? push_entry : mem[nxt_tag];
    nxt_addr    = nxt_entry.addr;
    nxt_data    = nxt_entry.data;
    nxt_we      = nxt_entry.we;
    nxt_size    = nxt_entry.size;
    nxt_fence   = nxt_entry.fence;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr  <= '0;
      issue_ptr <= '0;
      tail_ptr  <= '0;
    end else begin
      head_ptr  <= head_n;
      issue_ptr <= issue_n;
      tail_ptr  <= tail_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (truncate) begin
        for (int unsigned i = 0; i < DEPTH; i++) mem[i].killed <= 1'b1;
      end
      if (retry_inc) mem[head_ptr[TAG_W-1:0]].retry <= head_retry + RETRY_W'(1);
      if (push) mem[tail_ptr[TAG_W-1:0]] <= push_entry;
    end
  end

endmodule

// File: rtl/dcache_interface_v2.sv
// Bridge between the load/store unit and the DMEM port: in-order tracking,
// tag-matched responses, NACK rewind/replay, kill flush and fence ordering.
module dcache_interface_v2
  import drac_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 40,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_RETRY = MAX_RETRY_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ADDR_W-1:0]         req_addr_i,
  input  logic [DATA_W-1:0]         req_data_i,
  input  logic                      req_we_i,
  input  logic [1:0]                req_size_i,
  input  logic                      req_fence_i,
  input  logic                      req_kill_i,
  output logic                      resp_valid_o,
  output logic [DATA_W-1:0]         resp_data_o,
  output logic [$clog2(DEPTH)-1:0]  resp_tag_o,
  output logic [3:0]                resp_xcpt_o,
  output logic                      resp_err_o,
  output logic                      dmem_req_valid_o,
  input  logic                      dmem_req_ready_i,
  output logic [ADDR_W-1:0]         dmem_req_addr_o,
  output logic [DATA_W-1:0]         dmem_req_data_o,
  output logic                      dmem_req_we_o,
  output logic [1:0]                dmem_req_size_o,
  output logic [$clog2(DEPTH)-1:0]  dmem_req_tag_o,
  input  logic                      dmem_resp_valid_i,
  input  logic                      dmem_resp_nack_i,
  input  logic [$clog2(DEPTH)-1:0]  dmem_resp_tag_i,
  input  logic [DATA_W-1:0]         dmem_resp_data_i,
  input  logic [3:0]                dmem_xcpt_i,
  input  logic                      dmem_ordered_i
);

  localparam int unsigned TAG_W = $clog2(DEPTH);

  dcache_if_state_t state, state_n;
  dcache_entry_t    push_entry;
  dmem_xcpt_t       resp_xcpt_q;

  logic [TAG_W:0]          head_ptr, issue_ptr, tail_ptr;
  logic [TAG_W-1:0]        head_tag, nxt_tag;
  logic [RETRY_W-1:0]      head_retry;
  logic [ENTRY_ADDR_W-1:0] nxt_addr;
  logic [ENTRY_DATA_W-1:0] nxt_data;
  logic [1:0]              nxt_size;
  logic full, head_killed, issue_fence, nxt_pending, nxt_we, nxt_fence;
  logic accept, dmem_fire, resp_hit, req_valid_n;
  logic pop, issue_adv, rewind, truncate, retry_inc, emit, emit_data, emit_err;

  assign req_ready_o = !full && state == RUN && !req_kill_i;
  assign accept      = req_valid_i && req_ready_o;
  assign dmem_fire   = dmem_req_valid_o && dmem_req_ready_i;
  assign head_tag    = head_ptr[TAG_W-1:0];
  // Only an issued head can be answered; this also drops stale responses after reset.
  assign resp_hit    = dmem_resp_valid_i && head_ptr != issue_ptr && dmem_resp_tag_i == head_tag;
  assign resp_xcpt_o = resp_xcpt_q;

  always_comb begin
    push_entry       = '0;
    push_entry.addr  = ENTRY_ADDR_W'(req_addr_i);
    push_entry.data  = ENTRY_DATA_W'(req_data_i);
    push_entry.we    = req_we_i;
    push_entry.size  = req_size_i;
    push_entry.fence = req_fence_i;
  end

  dmem_req_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk_i),
    .rst         (rst_i),
    .push        (accept),
    .push_entry  (push_entry),
    .pop         (pop),
    .issue_adv   (issue_adv),
    .rewind      (rewind),
    .truncate    (truncate),
    .retry_inc   (retry_inc),
    .head_ptr    (head_ptr),
    .issue_ptr   (issue_ptr),
    .tail_ptr    (tail_ptr),
    .full        (full),
    .head_killed (head_killed),
    .head_retry  (head_retry),
    .issue_fence (issue_fence),
    .nxt_pending (nxt_pending),
    .nxt_tag     (nxt_tag),
    .nxt_addr    (nxt_addr),
    .nxt_data    (nxt_data),
    .nxt_we      (nxt_we),
    .nxt_size    (nxt_size),
    .nxt_fence   (nxt_fence)
  );

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    rewind    = 1'b0;
    retry_inc = 1'b0;
    issue_adv = dmem_fire;
    emit      = 1'b0;
    emit_data = 1'b0;
    emit_err  = 1'b0;
    unique case (state)
      RUN:    if (issue_ptr != tail_ptr && issue_fence) state_n = FENCE;
      REWIND: state_n = RUN;
      FENCE: begin
        if (head_ptr == issue_ptr && dmem_ordered_i) begin
          pop       = 1'b1;
          issue_adv = 1'b1;
          emit      = 1'b1;
          state_n   = RUN;
        end
      end
      default: state_n = RUN;
    endcase
    if (resp_hit) begin
      if (head_killed) begin
        pop = 1'b1;
      end else if (!dmem_resp_nack_i) begin
        pop       = 1'b1;
        emit      = 1'b1;
        emit_data = 1'b1;
      end else if (head_retry < RETRY_W'(MAX_RETRY)) begin
        retry_inc = 1'b1;
        rewind    = 1'b1;
        state_n   = REWIND;
      end else begin
        pop      = 1'b1;
        rewind   = 1'b1;
        emit     = 1'b1;
        emit_err = 1'b1;
        state_n  = REWIND;
      end
    end
    truncate = req_kill_i;
    if (req_kill_i && state_n != REWIND) state_n = RUN;
    req_valid_n = state_n == RUN && nxt_pending && !nxt_fence;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= RUN;
      dmem_req_valid_o <= 1'b0;
      dmem_req_addr_o  <= '0;
      dmem_req_data_o  <= '0;
      dmem_req_we_o    <= 1'b0;
      dmem_req_size_o  <= '0;
      dmem_req_tag_o   <= '0;
      resp_valid_o     <= 1'b0;
      resp_data_o      <= '0;
      resp_tag_o       <= '0;
      resp_xcpt_q      <= '0;
      resp_err_o       <= 1'b0;
    end else begin
      state            <= state_n;
      dmem_req_valid_o <= req_valid_n;
      dmem_req_addr_o  <= req_valid_n ? ADDR_W'(nxt_addr) : '0;
      dmem_req_data_o  <= req_valid_n ? DATA_W'(nxt_data) : '0;
      dmem_req_we_o    <= req_valid_n && nxt_we;
      dmem_req_size_o  <= req_valid_n ? nxt_size : '0;
      dmem_req_tag_o   <= req_valid_n ? nxt_tag : '0;
      resp_valid_o     <= emit;
      resp_data_o      <= emit_data ? dmem_resp_data_i : '0;
      resp_tag_o       <= emit ? head_tag : '0;
      resp_xcpt_q      <= emit_data ? dmem_xcpt_t'(dmem_xcpt_i) : '0;
      resp_err_o       <= emit_err;
    end
  end

  resp_tag_is_head: assert property (@(posedge clk_i) disable iff (rst_i)
    (dmem_resp_valid_i && head_ptr != issue_ptr) |-> dmem_resp_tag_i == head_tag);

endmodule

// File: doc/dcache_interface_v2.md
# dcache_interface_v2

Parametrised bridge between the datapath load/store unit and the SoC DMEM port. It buffers up to DEPTH in-order memory requests, issues them to DMEM, and matches responses by tag. It rewinds and replays on NACK with a bounded retry count, drops responses for killed requests, and serialises fences against DMEM_ORDERED. It sits between `datapath` and the `top_drac` DMEM pins.

## Interface
- DEPTH, 4: tracking-buffer entries; power of 2, ≥2.
- ADDR_W, 40: request address width.
- DATA_W, 64: data width.
- MAX_RETRY, 7: NACKs tolerated per request before an error response.
- clk_i  in  1  clock.
- rst_i  in  1  reset: synchronous, active-high.
- req_valid_i / req_ready_o  in/out  1  request handshake.
- req_addr_i  in  ADDR_W  request address.
- req_data_i  in  DATA_W  store data.
- req_we_i  in  1  store (1) or load (0).
- req_size_i  in  2  log2 of access bytes.
- req_fence_i  in  1  request is a fence; addr and data ignored.
- req_kill_i  in  1  flush all outstanding requests.
- resp_valid_o  out  1  response valid.
- resp_data_o  out  DATA_W  load data.
- resp_tag_o  out  log2(DEPTH)  buffer index of the response.
- resp_xcpt_o  out  4  {ma_ld, ma_st, pf_ld, pf_st}.
- resp_err_o  out  1  retry budget exhausted.
- dmem_req_valid_o / dmem_req_ready_i  out/in  1  DMEM handshake.
- dmem_req_addr_o, dmem_req_data_o, dmem_req_we_o, dmem_req_size_o, dmem_req_tag_o  out  ADDR_W/DATA_W/1/2/log2(DEPTH)  registered request fields.
- dmem_resp_valid_i, dmem_resp_nack_i  in  1  DMEM response and NACK.
- dmem_resp_tag_i  in  log2(DEPTH)  tag of the DMEM response.
- dmem_resp_data_i  in  DATA_W  DMEM load data.
- dmem_xcpt_i  in  4  DMEM exception bits, same order as resp_xcpt_o.
- dmem_ordered_i  in  1  DMEM has no outstanding memory operations.

## Operation
- Circular buffer with pointers head (oldest unretired), issue and tail. Pointers are log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
- Full: tail−head == DEPTH. req_ready_o = !full && state==RUN && !req_kill_i.
- Accept writes the entry at tail and increments tail. Per entry: valid, killed, fence, retry count.
- Issue: while issue≠tail and state==RUN, drive the entry at issue; issue advances on dmem_req_valid_o && dmem_req_ready_i. Tag = issue index.
- A fence entry is never sent to DMEM. When it reaches issue, the FSM enters FENCE. FENCE holds until head==issue and dmem_ordered_i=1, then the fence retires with resp_valid_o and the FSM returns to RUN.
- Response with tag==head index, nack=0: retire head (head+1, retry cleared) and emit resp_valid_o with data and xcpt. Exceptions do not trigger retry.
- Response with tag≠head: ignored (protocol error, covered by assertion).
- NACK on head, retry<MAX_RETRY: retry+1, issue←head, FSM→REWIND for one cycle (dmem_req_valid_o=0), then RUN.
- NACK on head, retry==MAX_RETRY: retire head with resp_valid_o=1, resp_err_o=1. Younger entries are still rewound.
- Kill: all entries between issue and tail are discarded (tail←issue). Issued entries are marked killed. Their later responses retire silently with no resp_valid_o. Killed entries hit by a NACK retire silently and are not replayed. A kill in FENCE returns the FSM to RUN.
- Simultaneous kill and response: the response is processed first, then the kill applies to the remaining entries.
- Simultaneous accept and retire: both take effect.

## Timing
- Reset (rst_i high at a clock edge): pointers 0, FSM RUN. All outputs 0 except req_ready_o=1 from the first cycle after reset.
- Accept at edge t → dmem_req_valid_o high from cycle t+1. All DMEM request outputs are registered.
- DMEM response at edge t → resp_* valid in cycle t+1. resp_valid_o is a one-cycle pulse.
- NACK at t → REWIND during t+1 → reissue from t+2.
- Held-off request: dmem_req_* must stay stable until ready, unless a kill or rewind changes the issue pointer.
- Reset mid-operation: in-flight DMEM responses are dropped without output.

## Structure
- Shared package drac_pkg holds:
  - the dcache_entry_t struct (addr, data, we, size, fence, killed, retry);
  - the dcache_if_state_t enum {RUN, REWIND, FENCE};
  - the dmem_xcpt_t packed struct;
  - the MAX_RETRY default.
- Sub-module dmem_req_queue holds the storage and pointer arithmetic (push, pop, rewind, truncate). The FSM and response matching stay in the top module.

## Test plan
- Four back-to-back loads at 0x100, 0x108, 0x110, 0x118 with DMEM ready → tags 0–3 issued; responses in order emit resp_data_o values 0xA0–0xA3. A fifth request while full sees req_ready_o=0.
- NACK on tag 0 with two entries issued → REWIND for one cycle, then tags 0 and 1 reissued; final responses still arrive in order.
- NACK on the same head 8 times with MAX_RETRY=7 → eighth NACK gives resp_valid_o=1, resp_err_o=1; the next entry proceeds.
- Kill with two entries issued and one queued → queued entry discarded, later responses for the issued entries give no resp_valid_o, buffer empty afterwards, req_ready_o=1.
- Fence behind a store, dmem_ordered_i held 0 for 5 cycles after the store response → fence resp_valid_o only after dmem_ordered_i rises; no DMEM request for the fence.
- dmem_xcpt_i=4'b0010 on a store response → resp_xcpt_o=4'b0010, no retry; rst_i mid-burst → all outputs 0 on the next cycle.
